// File: rtl/gen_reduce_pkg.sv
// gen_reduce_pkg: shared types and helpers for the gen_reduce consumer.
//   gen_reduce_state_t : controller state encoding
//   most_positive()    : largest signed value of a given width (min-accumulator seed)
//   most_negative()    : smallest signed value of a given width (max-accumulator seed)
// Both helpers return a MaxWidth-bit pattern; callers truncate to their own width.
package gen_reduce_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [1:0] {
        StDone,
        StStart,
        StCollect,
        StEmit
    } gen_reduce_state_t;

    // Low (width-1) bits set: 0111...1 once truncated to width.
    function automatic logic [MaxWidth-1:0] most_positive(input int unsigned width);
        return {MaxWidth{1'b1}} >> (MaxWidth - width + 1);
    endfunction

    // Complement of most_positive: 1000...0 once truncated to width.
    function automatic logic [MaxWidth-1:0] most_negative(input int unsigned width);
        return ~most_positive(width);
    endfunction

endpackage

// File: rtl/gen_reduce_alu.sv
// gen_reduce_alu: combinational single-beat accumulate step.
//   sum, count, cur_min, cur_max : current accumulator values
//   value                        : incoming stream value (signed)
//   accept                       : fold value in this cycle
//   sum_next .. max_next         : accumulators after the step
// Sum wraps in two's complement; count saturates at all-ones; min/max compare signed.
module gen_reduce_alu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic [WIDTH-1:0]       sum,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [WIDTH-1:0]       cur_min,
    input  logic [WIDTH-1:0]       cur_max,
    input  logic [WIDTH-1:0]       value,
    input  logic                   accept,
    output logic [WIDTH-1:0]       sum_next,
    output logic [COUNT_WIDTH-1:0] count_next,
    output logic [WIDTH-1:0]       min_next,
    output logic [WIDTH-1:0]       max_next
);

    always_comb begin
        sum_next   = sum;
        count_next = count;
        min_next   = cur_min;
        max_next   = cur_max;
        if (accept) begin
            sum_next = sum + value;
            if (count != {COUNT_WIDTH{1'b1}}) begin
                count_next = count + 1'b1;
            end
            if ($signed(value) < $signed(cur_min)) begin
                min_next = value;
            end
            if ($signed(value) > $signed(cur_max)) begin
                max_next = value;
            end
        end
    end

endmodule

// File: rtl/gen_reduce.sv
// gen_reduce: launches an attached generator, drains its value stream and reduces it to
// sum/count/min/max, then yields the tuple once to its own caller followed by _done.
//   _clock, _reset (async, active-low), _start (pulse, restarts from any state)
//   base/limit/step    : parameters captured on _start, forwarded as gen_base/limit/step
//   _ready/_valid      : result handshake; _out_0 sum, _out_1 count, _out_2 min, _out_3 max
//   _done              : high in every cycle spent idle after a result (and after reset)
//   gen_start          : one-cycle launch pulse; gen_ready high while collecting
//   gen_valid/gen_done/gen_out_0 : generator stream
module gen_reduce
    import gen_reduce_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic                   _start,
    input  logic [WIDTH-1:0]       base,
    input  logic [WIDTH-1:0]       limit,
    input  logic [WIDTH-1:0]       step,
    input  logic                   _ready,
    output logic                   _valid,
    output logic                   _done,
    output logic [WIDTH-1:0]       _out_0,
    output logic [COUNT_WIDTH-1:0] _out_1,
    output logic [WIDTH-1:0]       _out_2,
    output logic [WIDTH-1:0]       _out_3,
    output logic [WIDTH-1:0]       gen_base,
    output logic [WIDTH-1:0]       gen_limit,
    output logic [WIDTH-1:0]       gen_step,
    output logic                   gen_start,
    output logic                   gen_ready,
    input  logic                   gen_valid,
    input  logic                   gen_done,
    input  logic [WIDTH-1:0]       gen_out_0
);

    localparam logic [WIDTH-1:0] PosSentinel = WIDTH'(most_positive(WIDTH));
    localparam logic [WIDTH-1:0] NegSentinel = WIDTH'(most_negative(WIDTH));

    gen_reduce_state_t      state_q, state_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]       min_q, min_d;
    logic [WIDTH-1:0]       max_q, max_d;
    logic [WIDTH-1:0]       out0_q, out0_d;
    logic [COUNT_WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0]       out2_q, out2_d;
    logic [WIDTH-1:0]       out3_q, out3_d;
    logic                   valid_q, valid_d;
    logic                   gen_start_q, gen_start_d;
    logic [WIDTH-1:0]       gen_base_q, gen_base_d;
    logic [WIDTH-1:0]       gen_limit_q, gen_limit_d;
    logic [WIDTH-1:0]       gen_step_q, gen_step_d;

    logic                   accept;
    logic [WIDTH-1:0]       alu_sum;
    logic [COUNT_WIDTH-1:0] alu_count;
    logic [WIDTH-1:0]       alu_min;
    logic [WIDTH-1:0]       alu_max;

    assign accept = gen_valid && (state_q == StCollect);

    gen_reduce_alu #(
        .WIDTH       (WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_alu (
        .sum        (sum_q),
        .count      (count_q),
        .cur_min    (min_q),
        .cur_max    (max_q),
        .value      (gen_out_0),
        .accept     (accept),
        .sum_next   (alu_sum),
        .count_next (alu_count),
        .min_next   (alu_min),
        .max_next   (alu_max)
    );

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        count_d     = count_q;
        min_d       = min_q;
        max_d       = max_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        valid_d     = valid_q;
        gen_start_d = gen_start_q;
        gen_base_d  = gen_base_q;
        gen_limit_d = gen_limit_q;
        gen_step_d  = gen_step_q;

        if (_start) begin
            // Restart wins over everything, including a pending result in EMIT.
            gen_base_d  = base;
            gen_limit_d = limit;
            gen_step_d  = step;
            sum_d       = '0;
            count_d     = '0;
            min_d       = PosSentinel;
            max_d       = NegSentinel;
            valid_d     = 1'b0;
            gen_start_d = 1'b1;
            state_d     = StStart;
        end else begin
            unique case (state_q)
                StStart: begin
                    // gen_done here is left over from the previous run; ignore it.
                    gen_start_d = 1'b0;
                    state_d     = StCollect;
                end
                StCollect: begin
                    sum_d   = alu_sum;
                    count_d = alu_count;
                    min_d   = alu_min;
                    max_d   = alu_max;
                    if (gen_done) begin
                        // Load from ALU outputs so a beat coincident with done is included.
                        out0_d  = alu_sum;
                        out1_d  = alu_count;
                        out2_d  = alu_min;
                        out3_d  = alu_max;
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end
                end
                StEmit: begin
                    if (valid_q && _ready) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end
                end
                StDone: begin
                end
                default: state_d = StDone;
            endcase
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q     <= StDone;
            sum_q       <= '0;
            count_q     <= '0;
            min_q       <= PosSentinel;
            max_q       <= NegSentinel;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= PosSentinel;
            out3_q      <= NegSentinel;
            valid_q     <= 1'b0;
            gen_start_q <= 1'b0;
            gen_base_q  <= '0;
            gen_limit_q <= '0;
            gen_step_q  <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            valid_q     <= valid_d;
            gen_start_q <= gen_start_d;
            gen_base_q  <= gen_base_d;
            gen_limit_q <= gen_limit_d;
            gen_step_q  <= gen_step_d;
        end
    end

    assign _valid    = valid_q;
    assign _done     = (state_q == StDone);
    assign _out_0    = out0_q;
    assign _out_1    = out1_q;
    assign _out_2    = out2_q;
    assign _out_3    = out3_q;
    assign gen_base  = gen_base_q;
    assign gen_limit = gen_limit_q;
    assign gen_step  = gen_step_q;
    assign gen_start = gen_start_q;
    assign gen_ready = (state_q == StCollect);

endmodule

// File: tb/tb_gen_reduce.sv
// tb_gen_reduce: directed bench for gen_reduce with a behavioral generator model and a
// scoreboard; expected tuples are queued at stimulus time and popped at each handshake.
module tb_gen_reduce;

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] count;
        logic [31:0] mn;
        logic [31:0] mx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0, limit = '0, step = '0;
    logic        ready = 1'b1;
    logic        valid, done;
    logic [31:0] out0, out2, out3;
    logic [15:0] out1;
    logic [31:0] gen_base, gen_limit, gen_step;
    logic        gen_start, gen_ready;
    logic        gen_valid, gen_done;
    logic [31:0] gen_out;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    // Generator model controls
    int play[$];
    bit gap_en = 1'b0;
    bit coinc  = 1'b0;
    bit running;
    int pos;
    bit acc, show;
    int np;

    always #5 clk = ~clk;

    gen_reduce dut (
        ._clock    (clk),
        ._reset    (rst_n),
        ._start    (start),
        .base      (base),
        .limit     (limit),
        .step      (step),
        ._ready    (ready),
        ._valid    (valid),
        ._done     (done),
        ._out_0    (out0),
        ._out_1    (out1),
        ._out_2    (out2),
        ._out_3    (out3),
        .gen_base  (gen_base),
        .gen_limit (gen_limit),
        .gen_step  (gen_step),
        .gen_start (gen_start),
        .gen_ready (gen_ready),
        .gen_valid (gen_valid),
        .gen_done  (gen_done),
        .gen_out_0 (gen_out)
    );

    // Plays back 'play' as a stream; holds done high until relaunched.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_valid <= 1'b0;
            gen_done  <= 1'b0;
            gen_out   <= '0;
            running   <= 1'b0;
            pos       <= 0;
        end else if (gen_start || running) begin
            acc  = gen_valid && gen_ready;
            np   = gen_start ? 0 : pos + (acc ? 1 : 0);
            show = !(gap_en && acc);
            running <= 1'b1;
            pos     <= np;
            if (np < play.size()) begin
                gen_valid <= show;
                gen_out   <= play[np];
                gen_done  <= coinc && show && (np == play.size() - 1);
            end else begin
                gen_valid <= 1'b0;
                gen_done  <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare at every result handshake.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(valid), 64'(0));
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sum", 64'(out0), 64'(e.sum));
                check("count", 64'(out1), 64'(e.count));
                check("min", 64'(out2), 64'(e.mn));
                check("max", 64'(out3), 64'(e.mx));
            end
        end
    end

    task automatic pulse_start(input int b, input int l, input int s);
        start = 1'b1;
        base  = b;
        limit = l;
        step  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_seen", 64'(valid), 64'(1));
        check("done_low_in_emit", 64'(done), 64'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_after_hs", 64'(done), 64'(1));
        check("valid_cleared", 64'(valid), 64'(0));
    endtask

    task automatic push(input int s, input int c, input int mn, input int mx);
        res_t r;
        r.sum   = s;
        r.count = 16'(c);
        r.mn    = mn;
        r.mx    = mx;
        exp_q.push_back(r);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_gen_start", 64'(gen_start), 64'(0));
        check("rst_gen_ready", 64'(gen_ready), 64'(0));
        check("rst_out0", 64'(out0), 64'(0));
        check("rst_out1", 64'(out1), 64'(0));
        check("rst_out2", 64'(out2), 64'h7FFF_FFFF);
        check("rst_out3", 64'(out3), 64'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Non-empty range 1,4,7,10
        play = '{1, 4, 7, 10};
        push(22, 4, 1, 10);
        pulse_start(1, 11, 3);
        check("gen_start_pulse", 64'(gen_start), 64'(1));
        check("gen_base", 64'(gen_base), 64'(1));
        check("gen_limit", 64'(gen_limit), 64'(11));
        check("gen_step", 64'(gen_step), 64'(3));
        @(posedge clk);
        #1;
        check("gen_start_one_cycle", 64'(gen_start), 64'(0));
        check("gen_ready_collect", 64'(gen_ready), 64'(1));
        wait_valid(n);
        check("gen_ready_emit", 64'(gen_ready), 64'(0));
        wait_done();

        // Empty range with stale gen_done during START
        play = '{};
        push(0, 0, 32'h7FFF_FFFF, 32'h8000_0000);
        check("stale_gen_done", 64'(gen_done), 64'(1));
        pulse_start(5, 5, 1);
        wait_valid(n);
        check("empty_latency", 64'(n), 64'(2));
        wait_done();

        // Caller backpressure
        play  = '{0, 2, 4, 6, 8};
        ready = 1'b0;
        push(20, 5, 0, 8);
        pulse_start(0, 10, 2);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(valid), 64'(1));
            check("bp_out0", 64'(out0), 64'(20));
            check("bp_out1", 64'(out1), 64'(5));
            check("bp_out2", 64'(out2), 64'(0));
            check("bp_out3", 64'(out3), 64'(8));
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        wait_done();

        // Gaps and done coincident with last beat
        play   = '{-3, 9, -7};
        gap_en = 1'b1;
        coinc  = 1'b1;
        push(-1, 3, -7, 9);
        pulse_start(-3, 0, 0);
        wait_valid(n);
        wait_done();
        coinc = 1'b0;

        // Restart mid-COLLECT
        play = '{100, 200, 300, 400, 500, 600};
        pulse_start(100, 700, 100);
        repeat (4) @(posedge clk);
        #1;
        check("mid_collect", 64'(gen_ready), 64'(1));
        play   = '{0, 2, 4, 6, 8};
        gap_en = 1'b0;
        push(20, 5, 0, 8);
        pulse_start(0, 10, 2);
        wait_valid(n);
        wait_done();

        // Async reset mid-EMIT, then restart
        play  = '{1, 2};
        ready = 1'b0;
        pulse_start(1, 3, 1);
        wait_valid(n);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid), 64'(0));
        check("arst_gen_start", 64'(gen_start), 64'(0));
        check("arst_gen_ready", 64'(gen_ready), 64'(0));
        check("arst_out0", 64'(out0), 64'(0));
        check("arst_out2", 64'(out2), 64'h7FFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        play = '{5, -5, 2};
        push(2, 3, -5, 5);
        pulse_start(5, 0, 0);
        wait_valid(n);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
